// File: rtl/intdiv_sgn_seq.sv
// Sequential sign detector for SD2 redundant words (partial remainders,
// quotients). The operand is captured once and then scanned MSD-first,
// DPC digits per cycle. This avoids a long combinational sign ripple
// chain across all NDIG digits.
module intdiv_sgn_seq #(
  parameter  int NDIG       = 8,
  parameter  int DPC        = 2,
  parameter  int EARLY_EXIT = 1,
  localparam int G          = (NDIG + DPC - 1) / DPC,
  localparam int CW         = $clog2(G + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*NDIG-1:0] in_digits,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_neg,
  output logic            out_zero,
  output logic [CW-1:0]   out_ncyc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // The word is padded at the LSB end to a whole number of groups.
  // Padding digits are 00, so they read as zero.
  localparam int SHW  = 2 * G * DPC;
  localparam int PADW = SHW - 2 * NDIG;
  localparam logic [CW-1:0] K_LAST = CW'(G - 1);

  logic [1:0]     state;
  logic [CW-1:0]  k;
  logic           found;
  logic           neg_r;
  logic [SHW-1:0] sh_p0;
  logic [1:0]     gs;
  logic           accept;

  // Returns {nonzero, negative} for one group.
  // The sign comes from the highest nonzero digit.
  function automatic logic [1:0] grp_sign(input logic [2*DPC-1:0] g);
    logic [1:0] r;
    r = 2'b00;
    for (int i = DPC - 1; i >= 0; i--) begin
      if (!r[1] && g[2*i +: 2] != 2'b00) r = {1'b1, g[2*i +: 2] == 2'b11};
    end
    return r;
  endfunction

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign gs        = grp_sign(sh_p0[SHW-1 -: 2*DPC]);

  // Operand shift register: load on accept, move one group up per SCAN cycle.
  always_ff @(posedge clk) begin
    if (accept) sh_p0 <= SHW'(in_digits) << PADW;
    else if (state == SCAN) sh_p0 <= sh_p0 << (2 * DPC);
  end

  // Control FSM with the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      found    <= 1'b0;
      neg_r    <= 1'b0;
      out_neg  <= 1'b0;
      out_zero <= 1'b0;
      out_ncyc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SCAN;
            k     <= '0;
            found <= 1'b0;
          end
        end
        SCAN: begin
          // The first nonzero group decides the sign. Later groups cannot change it.
          if (gs[1] && !found) begin
            found <= 1'b1;
            neg_r <= gs[0];
          end
          if ((gs[1] && EARLY_EXIT != 0) || k == K_LAST) begin
            state    <= DONE;
            out_ncyc <= k + CW'(1);
            out_neg  <= found ? neg_r : (gs[1] & gs[0]);
            out_zero <= ~(found | gs[1]);
          end else begin
            k <= k + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
